// File: rtl/multicycle_datapath.sv
// Multicycle 16-bit-instruction core: FETCH/DECODE/EXEC/MEM/WB control, PC, IR,
// 16-entry register file and ALU, with req/ack instruction and data memory ports.
module multicycle_datapath #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned PC_W   = 5,
  parameter int unsigned DM_AW  = 4
) (
  input  logic              clk,
  input  logic              reset,
  output logic              instr_req,
  output logic [PC_W-1:0]   instr_addr,
  input  logic              instr_ack,
  input  logic [15:0]       instr_data,
  output logic              dm_req,
  output logic              dm_we,
  output logic [DM_AW-1:0]  dm_addr,
  output logic [DATA_W-1:0] dm_wdata,
  input  logic              dm_ack,
  input  logic [DATA_W-1:0] dm_rdata,
  output logic [PC_W-1:0]   pc,
  output logic              retired,
  output logic              halted
);

  localparam int unsigned NUM_REGS = 16;

  localparam logic [2:0] OP_LI   = 3'd0;
  localparam logic [2:0] OP_ADD  = 3'd1;
  localparam logic [2:0] OP_SUB  = 3'd2;
  localparam logic [2:0] OP_LD   = 3'd3;
  localparam logic [2:0] OP_ST   = 3'd4;
  localparam logic [2:0] OP_BEQ  = 3'd5;
  localparam logic [2:0] OP_HALT = 3'd6;
  localparam logic [2:0] OP_NOP  = 3'd7;

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALTED
  } state_t;

  state_t            state_q, state_d;
  logic [PC_W-1:0]   pc_q;
  logic [15:0]       ir_q;
  logic [DATA_W-1:0] regs [NUM_REGS];
  logic [DATA_W-1:0] a_q, b_q, alu_q, mdr_q, alu_res;

  logic [2:0]        op;
  logic [3:0]        rd, ra, rb;
  logic [PC_W-1:0]   target;
  logic              is_alu;

  assign op         = ir_q[15:13];
  assign rd         = ir_q[11:8];
  assign ra         = ir_q[7:4];
  assign rb         = ir_q[3:0];
  assign target     = PC_W'(ir_q[12:8]);
  assign is_alu     = (op == OP_LI) || (op == OP_ADD) || (op == OP_SUB);
  assign instr_addr = pc_q;
  assign pc         = pc_q;

  // ALU: immediate pass-through, add and subtract, all modulo 2^DATA_W
  always_comb begin
    alu_res = '0;
    case (op)
      OP_LI:   alu_res = DATA_W'(ir_q[7:0]);
      OP_ADD:  alu_res = a_q + b_q;
      OP_SUB:  alu_res = a_q - b_q;
      default: alu_res = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:  if (instr_ack) state_d = S_DECODE;
      S_DECODE: state_d = S_EXEC;
      S_EXEC: begin
        if (is_alu)                             state_d = S_WB;
        else if (op == OP_LD || op == OP_ST)    state_d = S_MEM;
        else if (op == OP_HALT)                 state_d = S_HALTED;
        else                                    state_d = S_FETCH;
      end
      S_MEM:    if (dm_ack) state_d = (op == OP_LD) ? S_WB : S_FETCH;
      S_WB:     state_d = S_FETCH;
      S_HALTED: state_d = S_HALTED;
      default:  state_d = S_FETCH;
    endcase
  end

  // Outputs decode from state; fetch request is held low while reset is asserted
  always_comb begin
    instr_req = 1'b0;
    dm_req    = 1'b0;
    dm_we     = 1'b0;
    dm_addr   = '0;
    dm_wdata  = '0;
    retired   = 1'b0;
    halted    = 1'b0;
    case (state_q)
      S_FETCH:  instr_req = reset;
      S_EXEC:   retired = (op == OP_BEQ) || (op == OP_NOP) || (op == OP_HALT);
      S_MEM: begin
        dm_req   = 1'b1;
        dm_we    = (op == OP_ST);
        dm_addr  = (op == OP_ST) ? DM_AW'(rd) : DM_AW'(ra);
        dm_wdata = a_q;
        retired  = dm_ack && (op == OP_ST);
      end
      S_WB:     retired = 1'b1;
      S_HALTED: halted = 1'b1;
      default:  ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q  <= '0;
      ir_q  <= '0;
      a_q   <= '0;
      b_q   <= '0;
      alu_q <= '0;
      mdr_q <= '0;
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else begin
      case (state_q)
        S_FETCH: begin
          if (instr_ack) begin
            ir_q <= instr_data;
            pc_q <= pc_q + PC_W'(1);
          end
        end
        S_DECODE: begin
          a_q <= regs[ra];
          b_q <= regs[rb];
        end
        S_EXEC: begin
          if (is_alu) alu_q <= alu_res;
          if (op == OP_BEQ && a_q == b_q) pc_q <= target;
        end
        S_MEM: if (dm_ack && op == OP_LD) mdr_q <= dm_rdata;
        S_WB:  regs[rd] <= (op == OP_LD) ? mdr_q : alu_q;
        default: ;
      endcase
    end
  end

endmodule

// File: doc/multicycle_datapath.md
Name: multicycle_datapath

Overview:
- Parametrised multicycle successor to the single-cycle 16-bit-instruction datapath.
- Contains the control FSM, program counter, instruction register, a 16-entry register file, ALU and operand/result registers.
- Fetches from an external instruction memory and accesses an external data memory through req/ack handshakes, so wait-stated memories are tolerated.
- Adds SUB, load, HALT and cycle-accurate retirement reporting.

Parameters:
- DATA_W, 8: register, ALU and data-memory word width; must be >= 8.
- PC_W, 5: instruction address width; must be >= 5.
- DM_AW, 4: data-memory address width; must be >= 4.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous active-low reset; design is held in reset while 0.
- instr_req  out  1  fetch request.
- instr_addr  out  PC_W  fetch address (= PC).
- instr_ack  in  1  fetch data valid this cycle.
- instr_data  in  16  fetched instruction.
- dm_req  out  1  data-memory request.
- dm_we  out  1  1 = store, 0 = load.
- dm_addr  out  DM_AW  data-memory address.
- dm_wdata  out  DATA_W  store data.
- dm_ack  in  1  access complete; load data valid this cycle.
- dm_rdata  in  DATA_W  load data.
- pc  out  PC_W  current PC.
- retired  out  1  one-cycle pulse as each instruction completes.
- halted  out  1  core stopped by HALT.

Behaviour:
- Instruction encoding:
  - [15:13] op
  - [12:8] branch target T
  - [11:8] rd
  - [7:4] ra
  - [3:0] rb
  - [7:0] imm8, zero-extended to DATA_W
- Ops:
  - 000 LI: R[rd]=imm8.
  - 001 ADD: R[rd]=R[ra]+R[rb], modulo 2^DATA_W, no carry out.
  - 010 SUB: R[rd]=R[ra]-R[rb], modulo 2^DATA_W.
  - 011 LD: R[rd]=DM[ra field].
  - 100 ST: DM[rd field]=R[ra].
  - 101 BEQ: if R[ra]==R[rb], PC=T.
  - 110 HALT.
  - 111 NOP.
- Memory address fields and T are zero-extended to DM_AW / PC_W.
- R0 is an ordinary register.
- FSM states: FETCH, DECODE, EXEC, MEM, WB, HALTED.
- FETCH:
  - instr_req=1, instr_addr=PC, both held stable until instr_ack.
  - On ack: IR<=instr_data, PC<=PC+1 (wraps modulo 2^PC_W), go to DECODE.
- DECODE: A<=R[ra], B<=R[rb]; go to EXEC.
- EXEC, by op:
  - LI/ADD/SUB: ALUOut<=result; go to WB.
  - LD/ST: go to MEM.
  - BEQ: if A==B, PC<=T; retired=1; go to FETCH.
  - NOP: retired=1; go to FETCH.
  - HALT: retired=1; go to HALTED.
- MEM:
  - dm_req=1; dm_we, dm_addr and dm_wdata (=A) held stable until dm_ack.
  - On ack, LD: MDR<=dm_rdata, go to WB.
  - On ack, ST: retired=1, go to FETCH.
- WB: R[rd]<=ALUOut (LI/ADD/SUB) or MDR (LD); retired=1; go to FETCH.
- Register-file writes occur only in WB.
- HALTED:
  - Terminal state; halted=1, no requests issued.
  - Left only by reset.
- Latency with zero-wait memories (ack in the first request cycle):
  - NOP/BEQ/HALT: 3 cycles.
  - ALU ops/ST: 4 cycles.
  - LD: 5 cycles.
  - Each wait cycle of ack adds one cycle.
- Ack is ignored when the corresponding req is 0.
- req never drops before ack.
- Reset (async, any state, including mid-handshake):
  - PC=0, IR=0, all registers/A/B/ALUOut/MDR=0, state=FETCH.
  - Outputs: instr_req=0, dm_req=0, dm_we=0, dm_addr=0, dm_wdata=0, retired=0, halted=0.
  - instr_req rises in the first cycle after reset deasserts.
  - An in-flight memory access is abandoned; a late ack is ignored.
- retired is registered-free: it is combinational from state, asserted only in the completing state.

Test Plan:
- ADD wrap, zero-wait memories, DATA_W=8: LI R1,0xF0; LI R2,0x20; ADD R3=R1+R2 -> R3=0x10; retired pulses at cycles 4, 8, 12.
- SUB wrap: R1=0x01, R2=0x02, SUB R4 -> R4=0xFF.
- BEQ taken vs not-taken:
  - Equal operands, T=0x1A -> next instr_addr=0x1A.
  - Unequal operands at PC=3 -> next instr_addr=4.
- Wait-stated memories:
  - ST R5(=0x3C) to address 9 with dm_ack delayed 3 cycles -> dm_req, dm_we=1, dm_addr=9, dm_wdata=0x3C stable for 4 cycles; a following LD from 9 -> R6=0x3C.
  - instr_ack delayed 2 cycles -> instr_addr stable throughout.
- PC wrap and HALT, PC_W=5: NOP at address 31 -> next fetch address 0; HALT there -> halted=1, instr_req stays 0 for 20 cycles.
- Reset mid-MEM: reset=0 while dm_req=1 -> dm_req=0 in the same cycle, all registers 0; a stale dm_ack after release has no effect; fetch restarts at address 0.
